// File: rtl/ecc_sel_pkg.sv
// rtl/ecc_sel_pkg.sv - shared defaults, select encoding and queue state type for the ECC result-select buffer
package ecc_sel_pkg;

    // Default geometry: 5 byte lanes per result word, 3 selectable sources.
    localparam int ECC_W     = 8;
    localparam int ECC_LANES = 5;
    localparam int ECC_N_SRC = 3;
    localparam int ECC_SEL_W = 3;
    localparam int ECC_CNT_W = 16;

    // inst value meaning "no source selected".
    localparam int SEL_IDLE = 0;

    // Occupancy of the 2-entry queue; the encoding equals the entry count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } queue_state_t;

endpackage

// File: rtl/ecc_fifo2.sv
// rtl/ecc_fifo2.sv - two-entry FIFO with push/pop, occupancy state and held head-of-queue output
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset; clears both entries and pointers
//   push_i       write push_data_i at the tail (ignored when full)
//   push_data_i  entry to enqueue
//   pop_i        advance the read pointer (ignored when empty)
//   head_o       head entry; when empty, the most recently dequeued entry
//   valid_o      queue holds at least one entry
//   full_o       queue holds two entries
module ecc_fifo2
    import ecc_sel_pkg::*;
#(
    parameter int EW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [EW-1:0] push_data_i,
    input  logic          pop_i,
    output logic [EW-1:0] head_o,
    output logic          valid_o,
    output logic          full_o
);

    queue_state_t  state_q;
    queue_state_t  state_d;
    logic [EW-1:0] mem_q [2];
    logic          wr_ptr_q;
    logic          rd_ptr_q;
    logic          do_push;
    logic          do_pop;

    assign do_push = push_i && (state_q != ST_FULL);
    assign do_pop  = pop_i  && (state_q != ST_EMPTY);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: simultaneous push and pop leaves occupancy unchanged.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_EMPTY: begin
                if (do_push) begin
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (do_push && !do_pop) begin
                    state_d = ST_FULL;
                end else if (do_pop && !do_push) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (do_pop) begin
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // Storage and pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    // Outputs. Once empty, the read pointer has moved past the last dequeued
    // entry, so that entry sits at ~rd_ptr_q. A push into an empty queue
    // writes at wr_ptr_q == rd_ptr_q, so the held entry is never disturbed
    // while the head is invalid.
    always_comb begin
        valid_o = (state_q != ST_EMPTY);
        full_o  = (state_q == ST_FULL);
        head_o  = valid_o ? mem_q[rd_ptr_q] : mem_q[~rd_ptr_q];
    end

endmodule

// File: rtl/ecc_result_select_buf.sv
// rtl/ecc_result_select_buf.sv - source select, 2-deep result buffer, sticky select error and beat counter
//
// Optional feature macro: ECC_RESULT_PARITY_EN (adds out_parity, per-lane even parity of the head beat)
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   inst       source select: k in 1..N_SRC picks source k-1, 0 is idle, above N_SRC is illegal
//   src_data   N_SRC concatenated LANES*W words, source 0 in the low bits
//   src_valid  per-source valid
//   src_ready  per-source ready; only the selected source can see ready, and only when not full
//   out_data   head-of-queue word (last dequeued word when empty)
//   out_valid  queue non-empty
//   out_ready  downstream accept
//   out_src    inst value captured with the head beat
//   sel_err    sticky: an illegal inst value was seen
//   beat_cnt   wrapping count of beats delivered downstream
//   out_parity (macro only) per-lane parity of the head beat
module ecc_result_select_buf
    import ecc_sel_pkg::*;
#(
    parameter int W     = ECC_W,
    parameter int LANES = ECC_LANES,
    parameter int N_SRC = ECC_N_SRC,
    parameter int SEL_W = ECC_SEL_W,
    parameter int CNT_W = ECC_CNT_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [SEL_W-1:0]         inst,
    input  logic [N_SRC*LANES*W-1:0] src_data,
    input  logic [N_SRC-1:0]         src_valid,
    output logic [N_SRC-1:0]         src_ready,
    output logic [LANES*W-1:0]       out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [SEL_W-1:0]         out_src,
    output logic                     sel_err,
`ifdef ECC_RESULT_PARITY_EN
    output logic [LANES-1:0]         out_parity,
`endif
    output logic [CNT_W-1:0]         beat_cnt
);

    localparam int WW = LANES * W;
`ifdef ECC_RESULT_PARITY_EN
    localparam int EW = WW + SEL_W + LANES;
`else
    localparam int EW = WW + SEL_W;
`endif

    logic [WW-1:0]    sel_word;
    logic             sel_valid;
    logic             sel_legal;
    logic             sel_illegal;
    logic             push;
    logic             pop;
    logic             fifo_valid;
    logic             fifo_full;
    logic [EW-1:0]    push_entry;
    logic [EW-1:0]    head_entry;
    logic             sel_err_q;
    logic             sel_err_d;
    logic [CNT_W-1:0] beat_cnt_q;
    logic [CNT_W-1:0] beat_cnt_d;

    assign sel_illegal = (inst > SEL_W'(N_SRC));
    assign sel_legal   = (inst != SEL_W'(SEL_IDLE)) && !sel_illegal;

    // Select mux and ready generation. Ready is a function of inst and
    // occupancy only, never of out_ready.
    always_comb begin
        sel_word  = '0;
        sel_valid = 1'b0;
        src_ready = '0;
        for (int s = 0; s < N_SRC; s++) begin
            if (inst == SEL_W'(s + 1)) begin
                sel_word     = src_data[s*WW +: WW];
                sel_valid    = src_valid[s];
                src_ready[s] = ~fifo_full;
            end
        end
    end

    assign push = sel_legal && sel_valid && !fifo_full;
    assign pop  = fifo_valid && out_ready;

`ifdef ECC_RESULT_PARITY_EN
    logic [LANES-1:0] push_parity;

    always_comb begin
        push_parity = '0;
        for (int l = 0; l < LANES; l++) begin
            push_parity[l] = ^sel_word[l*W +: W];
        end
    end

    assign push_entry = {push_parity, inst, sel_word};
    assign out_parity = head_entry[WW+SEL_W +: LANES];
`else
    assign push_entry = {inst, sel_word};
`endif

    ecc_fifo2 #(
        .EW(EW)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (reset),
        .push_i     (push),
        .push_data_i(push_entry),
        .pop_i      (pop),
        .head_o     (head_entry),
        .valid_o    (fifo_valid),
        .full_o     (fifo_full)
    );

    assign out_data  = head_entry[WW-1:0];
    assign out_src   = head_entry[WW +: SEL_W];
    assign out_valid = fifo_valid;

    // Sticky error and delivered-beat counter (wraps naturally at 2^CNT_W).
    always_comb begin
        sel_err_d  = sel_err_q | sel_illegal;
        beat_cnt_d = pop ? beat_cnt_q + CNT_W'(1) : beat_cnt_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sel_err_q  <= 1'b0;
            beat_cnt_q <= '0;
        end else begin
            sel_err_q  <= sel_err_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign sel_err  = sel_err_q;
    assign beat_cnt = beat_cnt_q;

endmodule

// File: doc/ecc_result_select_buf.md
Name: ecc_result_select_buf

Overview:
Parametrised successor to the ECC datapath's result-select register. It selects one of N_SRC multi-lane result sources by `inst` and accepts beats under a valid/ready handshake. Accepted beats are buffered in a 2-entry queue and presented to the downstream stage (point-add/encrypt controller) with valid/ready backpressure. It also keeps a sticky illegal-select flag and a wrapping beat counter.

Parameters:
- W, 8, bits per lane (byte of the field element)
- LANES, 5, lanes per result word
- N_SRC, 3, number of selectable sources
- SEL_W, 3, width of `inst`
- CNT_W, 16, width of the delivered-beat counter

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- inst  in  SEL_W  source select; value k in 1..N_SRC selects source k-1; 0 means idle
- src_data  in  N_SRC*LANES*W  concatenated source words; source s occupies bits [(s+1)*LANES*W-1 : s*LANES*W]
- src_valid  in  N_SRC  per-source valid
- src_ready  out  N_SRC  per-source ready
- out_data  out  LANES*W  head-of-queue word
- out_valid  out  1  queue non-empty
- out_ready  in  1  downstream accept
- out_src  out  SEL_W  `inst` value captured with the head beat
- sel_err  out  1  sticky illegal-select flag
- beat_cnt  out  CNT_W  count of beats delivered downstream

Behaviour:
- Reset, asynchronous while `reset`=0:
  - queue empty; out_valid=0
  - out_data=0, out_src=0, sel_err=0, beat_cnt=0
  - all storage entries cleared
- Reset mid-operation discards buffered beats. No partial beat survives.
- Queue state machine: EMPTY (count 0), ONE (count 1), FULL (count 2). Transitions follow push/pop:
  - push only: count+1
  - pop only: count-1
  - both together: count unchanged (legal in ONE only)
- src_ready[s] = 1 only if inst==s+1 and count<2. There is no full-queue bypass, so ready never depends on out_ready. All other src_ready bits are 0.
- Push: occurs when inst in 1..N_SRC and src_valid[inst-1] and src_ready[inst-1]. It writes src word inst-1 and the inst value at the tail on that edge.
- Pop: occurs when out_valid and out_ready. The read pointer advances and beat_cnt increments, wrapping from 2^CNT_W-1 to 0.
- Latency: a beat pushed at edge N is visible with out_valid=1 after edge N. This is 1-cycle minimum. Order is strictly FIFO.
- In EMPTY, out_data and out_src hold the most recently dequeued beat (0 after reset). out_valid=0.
- Stability: head data/out_src are stable while out_valid=1 and out_ready=0.
- inst==0: no push, no error; buffered beats still drain.
- inst in N_SRC+1..2^SEL_W-1: no push, all src_ready=0. sel_err is set on the next edge and stays set until reset.
- Changing `inst` between cycles is legal. Only the currently selected source can be accepted.
- Pointers are 1-bit and wrap modulo 2.

Optional Feature:
- Macro: ECC_RESULT_PARITY_EN
- Defined:
  - extra output `out_parity` [LANES]; bit l is the even parity (XOR reduction) of lane l of the head beat
  - parity is computed at push and stored with the entry; it is 0 after reset and held in EMPTY like out_data
- Undefined: the port and its storage do not exist; all other behaviour is identical.

Decomposition:
- Package ecc_sel_pkg:
  - default W/LANES/N_SRC/SEL_W/CNT_W localparams
  - SEL_IDLE=0
  - queue state encoding (ST_EMPTY/ST_ONE/ST_FULL) and a typedef for it
- Sub-module ecc_fifo2: 2-entry queue with parametrised entry width (data + src, + parity when enabled), push/pop, count/state, and async active-low reset. The top level holds the select mux, ready generation, sel_err, and beat_cnt.

Test Plan:
1. Assert reset=0 mid-stream with 2 beats queued, then release → out_valid=0, out_data=0, beat_cnt=0, sel_err=0 within the same cycle of assertion.
2. inst=2, src_valid=3'b010, source 1 word 0x0504030201 for one cycle, out_ready=1 → out_valid=1 the next cycle with out_data=0x0504030201 and out_src=2; beat_cnt=1 after the pop.
3. out_ready=0, inst=1 streaming words A, B, C → src_ready[0] drops after 2 pushes. Then out_ready=1 → A, B, C delivered in order with no loss or duplicate.
4. inst=5 with N_SRC=3 → src_ready=0 and sel_err=1 next edge. Then inst=1 → sel_err remains 1 and pushes resume.
5. Preload beat_cnt to 0xFFFE via 3 pops after forcing → it reads 0xFFFF, then 0x0000.
6. With ECC_RESULT_PARITY_EN, push lane bytes 0x01,0x03,0x07,0x00,0xFF → out_parity=5'b00101 (lane0=1, lane1=0, lane2=1, lane3=0, lane4=0).
